// File: rtl/vr_pkg.sv
// -----------------------------------------------------------------------------
// vr_pkg
// Shared types and helpers for the valid/ready round-robin arbiter.
//   state_t  : arbiter FSM states (IDLE = no grant, GRANT = grant held)
//   DEF_*    : default N_REQ / DW / MAX_BURST values
//   pick_t   : result of a round-robin search {found, idx}
//   rr_pick  : first set request at or after a start index, wrapping modulo n
// -----------------------------------------------------------------------------
package vr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

    // The search helper is written once at the largest supported width;
    // callers zero-extend their request vector and pass the live count n.
    localparam int MAX_REQ = 16;
    localparam int PICK_IW = 4;
    localparam int PICK_JW = PICK_IW + 1;   // one spare bit for the wrap sum

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] idx;
    } pick_t;

    // Rotate the request vector so that 'start' lands on bit 0, take the
    // lowest set bit, then rotate the offset back. Rotation is modulo n, so
    // bits at or above n never participate (non power-of-two counts).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PICK_IW-1:0] start,
                                      input int                 n);
        pick_t               p;
        logic [MAX_REQ-1:0]  rot;
        logic [PICK_JW-1:0]  j;
        logic [PICK_JW-1:0]  off;
        logic                found;

        rot   = '0;
        off   = '0;
        found = 1'b0;

        for (int k = 0; k < MAX_REQ; k++) begin
            j = {1'b0, start} + PICK_JW'(k);
            if (j >= PICK_JW'(n)) j = j - PICK_JW'(n);
            if (k < n) rot[k] = req[PICK_IW'(j)];
        end

        // Scan downward so the last hit kept is the lowest offset.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = PICK_JW'(k);
            end
        end

        j = {1'b0, start} + off;
        if (j >= PICK_JW'(n)) j = j - PICK_JW'(n);

        p.found = found;
        p.idx   = found ? PICK_IW'(j) : '0;
        return p;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// -----------------------------------------------------------------------------
// rr_pick_comb
// Combinational round-robin pick: rotate / priority-encode / unrotate.
//   req_i   [N_REQ] : request vector
//   start_i [IDW]   : index searched first (must be < N_REQ)
//   found_o         : at least one request is set
//   idx_o   [IDW]   : chosen requester (0 when found_o = 0)
// -----------------------------------------------------------------------------
module rr_pick_comb
    import vr_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   start_i,
    output logic             found_o,
    output logic [IDW-1:0]   idx_o
);

    pick_t pick;

    assign pick    = rr_pick(MAX_REQ'(req_i), PICK_IW'(start_i), N_REQ);
    assign found_o = pick.found;
    assign idx_o   = IDW'(pick.idx);

endmodule

// File: rtl/vr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vr_rr_arbiter
// Shares one downstream valid/ready channel among N_REQ upstream masters.
// A grant is held for up to MAX_BURST beats, or until the owner drops valid,
// then rotates round-robin with no bubble when another requester is waiting.
//   clk, rst (async, active-high)
//   s_valid [N_REQ]    in  : per-requester valid
//   s_ready [N_REQ]    out : per-requester ready (only the owner sees m_ready)
//   s_data  [N_REQ*DW] in  : requester i at bits [i*DW +: DW]
//   m_valid / m_ready / m_data : downstream channel
//   grant_vld, grant_idx [IDW]  : current grant (grant_idx = 0 when idle)
// -----------------------------------------------------------------------------
module vr_rr_arbiter
    import vr_pkg::*;
#(
    parameter int  N_REQ     = DEF_N_REQ,
    parameter int  DW        = DEF_DW,
    parameter int  MAX_BURST = DEF_MAX_BURST,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    s_valid,
    output logic [N_REQ-1:0]    s_ready,
    input  logic [N_REQ*DW-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW-1:0]       m_data,
    output logic                grant_vld,
    output logic [IDW-1:0]      grant_idx
);

    localparam int             BCW       = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_REQ - 1);

    state_t          state_q,     state_d;
    logic [IDW-1:0]  grant_idx_q, grant_idx_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;

    logic            granted;
    logic            owner_valid;
    logic            beat;
    logic            rel_grant;
    logic [IDW-1:0]  next_ptr;
    logic [IDW-1:0]  pick_start;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    // ---------------------------------------------------------------- datapath
    // Everything here is decoded from the grant register only, so m_ready
    // never reaches m_valid combinationally.
    // NOTE: every signal assigned in an always_comb gets a value before any
    // branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        granted     = (state_q == GRANT);
        owner_valid = s_valid[grant_idx_q];
        m_valid     = granted & owner_valid;
        m_data      = s_data[grant_idx_q*DW +: DW];
        s_ready     = '0;
        if (granted) s_ready[grant_idx_q] = m_ready;

        beat      = m_valid & m_ready;
        // Release on the last beat of a burst, or as soon as the owner idles.
        rel_grant = granted & (~owner_valid | (beat & (burst_cnt_q == LAST_BEAT)));

        next_ptr   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
        // On release the search starts just past the old owner, which makes
        // it the lowest-priority candidate in the same-edge re-arbitration.
        pick_start = granted ? next_ptr : rr_ptr_q;

        grant_vld  = granted;
        grant_idx  = grant_idx_q;
    end

    rr_pick_comb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i   (s_valid),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    grant_idx_d = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (rel_grant) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        grant_idx_d = pick_idx;       // handover, no bubble
                    end else begin
                        state_d     = IDLE;
                        grant_idx_d = '0;
                    end
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + 1'b1; // frozen while stalled
                end
            end
            default: begin
                state_d     = IDLE;
                grant_idx_d = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vr_rr_arbiter
// Self-checking bench for vr_rr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Each requester is fed from a queue: valid while its queue is non-empty,
// data = queue head, head popped on a handshake. A behavioural model tracks
// the current owner, the rotation pointer and the beats taken in the burst.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vr_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  s_valid;
    logic [N-1:0]  s_ready;
    logic [N*DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          grant_vld;
    logic [1:0]    grant_idx;

    vr_rr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // requester sources
    logic [7:0] src_q [N][$];

    // model state: owner = -1 when no grant
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_cnt   = 0;

    // beat log
    int         beat_own_q [$];
    logic [7:0] beat_dat_q [$];
    int         beat_cyc_q [$];

    function automatic int mdl_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++)
            if (req[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] exp_vec();
        logic       ev;
        logic [7:0] ed;
        logic [3:0] er;
        ev = 1'b0; ed = 8'h00; er = 4'h0;
        if (mdl_owner >= 0) begin
            ev = s_valid[mdl_owner];
            ed = ev ? s_data[mdl_owner*DW +: DW] : 8'h00;
            if (m_ready) er[mdl_owner] = 1'b1;
        end
        return {ev, ed, er, (mdl_owner >= 0) ? 1'b1 : 1'b0,
                (mdl_owner >= 0) ? 2'(mdl_owner) : 2'b00};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {m_valid, m_valid ? m_data : 8'h00, s_ready, grant_vld, grant_idx};
    endfunction

    task automatic apply_src();
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        v = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                v[i]            = 1'b1;
                d[i*DW +: DW]   = src_q[i][0];
            end
        end
        s_valid = v;
        s_data  = d;
    endtask

    task automatic model_edge();
        bit beat;
        if (rst) begin
            mdl_owner = -1; mdl_ptr = 0; mdl_cnt = 0;
        end else begin
            beat = (mdl_owner >= 0) && s_valid[mdl_owner] && m_ready;
            if (beat) begin
                beat_own_q.push_back(mdl_owner);
                beat_dat_q.push_back(s_data[mdl_owner*DW +: DW]);
                beat_cyc_q.push_back(cyc);
                void'(src_q[mdl_owner].pop_front());
            end
            if (mdl_owner < 0) begin
                mdl_owner = mdl_pick(s_valid, mdl_ptr);
                mdl_cnt   = 0;
            end else if (!s_valid[mdl_owner] || (beat && mdl_cnt == MB - 1)) begin
                mdl_ptr   = (mdl_owner + 1) % N;
                mdl_owner = mdl_pick(s_valid, mdl_ptr);
                mdl_cnt   = 0;
            end else if (beat) begin
                mdl_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        beat_own_q.delete();
        beat_dat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        apply_src();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({m_valid, s_ready, grant_vld, grant_idx} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=00", {m_valid, s_ready, grant_vld, grant_idx});
        end
        // requests present while reset is held must not be granted
        for (int i = 0; i < N; i++) src_q[i].push_back(8'(8'hE0 + i));
        for (int c = 0; c < 2; c++) begin
            apply_src();
            m_ready = 1'b1;
            #1;
            checks++;
            if ({m_valid, s_ready, grant_vld, grant_idx} !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold c=%0d got=%h exp=00", c, {m_valid, s_ready, grant_vld, grant_idx});
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_single();
        int exp_c;
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) src_q[1].push_back(8'(8'h10 + k));
        for (int c = 0; c < 11; c++) begin
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (beat_dat_q.size() != 8) begin
            errors++;
            $display("FAIL single_count got=%0d exp=8", beat_dat_q.size());
        end
        for (int k = 0; k < 8 && k < beat_dat_q.size(); k++) begin
            exp_c = beat_cyc_q[0] + k;
            checks++;
            if (beat_own_q[k] !== 1 || beat_dat_q[k] !== 8'(8'h10 + k) || beat_cyc_q[k] !== exp_c) begin
                errors++;
                $display("FAIL single_beat k=%0d got own=%0d dat=%h cyc=%0d exp own=1 dat=%h cyc=%0d",
                         k, beat_own_q[k], beat_dat_q[k], beat_cyc_q[k], 8'(8'h10 + k), exp_c);
            end
        end
    endtask

    task automatic test_saturated();
        int exp_own [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        int got_own;
        int got_gap;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) src_q[i].push_back(8'(i * 16 + k));
        for (int c = 0; c < 24; c++) begin
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL saturated c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        for (int k = 0; k < 17; k++) begin
            got_own = (k < beat_own_q.size()) ? beat_own_q[k] : -1;
            got_gap = (k < beat_cyc_q.size()) ? beat_cyc_q[k] - beat_cyc_q[0] : -1;
            checks++;
            if (got_own !== exp_own[k] || got_gap !== k) begin
                errors++;
                $display("FAIL saturated_order k=%0d got own=%0d gap=%0d exp own=%0d gap=%0d",
                         k, got_own, got_gap, exp_own[k], k);
            end
        end
    endtask

    task automatic test_stall();
        int         exp_own [5] = '{2,2,2,2,0};
        logic [7:0] exp_dat [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h01};
        int         got_own;
        logic [7:0] got_dat;
        do_reset();
        for (int k = 0; k < 5; k++) src_q[2].push_back(8'(8'hA0 + k));
        for (int c = 0; c < 13; c++) begin
            if (c == 1) src_q[0].push_back(8'h01);
            m_ready = !(c >= 3 && c <= 7);
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c >= 3 && c <= 7) begin
                checks++;
                if (grant_idx !== 2'd2 || m_data !== 8'hA2 || m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got idx=%0d dat=%h vld=%b exp idx=2 dat=a2 vld=1",
                             c, grant_idx, m_data, m_valid);
                end
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            got_own = (k < beat_own_q.size()) ? beat_own_q[k] : -1;
            got_dat = (k < beat_dat_q.size()) ? beat_dat_q[k] : 8'hxx;
            checks++;
            if (got_own !== exp_own[k] || got_dat !== exp_dat[k]) begin
                errors++;
                $display("FAIL stall_order k=%0d got own=%0d dat=%h exp own=%0d dat=%h",
                         k, got_own, got_dat, exp_own[k], exp_dat[k]);
            end
        end
    endtask

    task automatic test_early_release();
        int exp_own [4] = '{3,3,0,0};
        int got_own;
        int n3;
        do_reset();
        m_ready = 1'b1;
        src_q[3].push_back(8'h30);
        src_q[3].push_back(8'h31);
        for (int c = 0; c < 7; c++) begin
            if (c == 1) begin
                src_q[0].push_back(8'h05);
                src_q[0].push_back(8'h06);
            end
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 4) begin
                checks++;
                if (grant_vld !== 1'b1 || grant_idx !== 2'd0) begin
                    errors++;
                    $display("FAIL early_handover got vld=%b idx=%0d exp vld=1 idx=0", grant_vld, grant_idx);
                end
            end
            tick();
        end
        n3 = 0;
        foreach (beat_own_q[k]) if (beat_own_q[k] == 3) n3++;
        checks++;
        if (n3 != 2) begin
            errors++;
            $display("FAIL early_beats3 got=%0d exp=2", n3);
        end
        for (int k = 0; k < 4; k++) begin
            got_own = (k < beat_own_q.size()) ? beat_own_q[k] : -1;
            checks++;
            if (got_own !== exp_own[k]) begin
                errors++;
                $display("FAIL early_order k=%0d got=%0d exp=%0d", k, got_own, exp_own[k]);
            end
        end
    endtask

    task automatic test_contention_idle();
        int exp_own [4] = '{3,3,1,1};
        int got_own;
        do_reset();
        m_ready = 1'b1;
        src_q[1].push_back(8'h11);           // leaves the pointer at 2
        for (int c = 0; c < 4; c++) begin
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL contention_pre c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        clear_logs();
        src_q[1].push_back(8'h21); src_q[1].push_back(8'h22);
        src_q[3].push_back(8'h41); src_q[3].push_back(8'h42);
        for (int c = 0; c < 8; c++) begin
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL contention c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            got_own = (k < beat_own_q.size()) ? beat_own_q[k] : -1;
            checks++;
            if (got_own !== exp_own[k]) begin
                errors++;
                $display("FAIL contention_order k=%0d got=%0d exp=%0d", k, got_own, exp_own[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h50 + k));
        for (int c = 0; c < 2; c++) begin
            if (c == 1) src_q[0].push_back(8'h60);
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_pre c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        // second beat of grant 1 is on the bus; reset hits mid-cycle
        apply_src();
        #1;
        checks++;
        if (m_valid !== 1'b1 || grant_idx !== 2'd1 || m_data !== 8'h51) begin
            errors++;
            $display("FAIL rstmid_beat2 got vld=%b idx=%0d dat=%h exp vld=1 idx=1 dat=51", m_valid, grant_idx, m_data);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, s_ready, grant_vld, grant_idx} !== 8'h00 || s_valid === 4'h0) begin
            errors++;
            $display("FAIL rstmid_async got=%h sv=%b exp=00 with requests present",
                     {m_valid, s_ready, grant_vld, grant_idx}, s_valid);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_post c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                checks++;
                if (grant_vld !== 1'b1 || grant_idx !== 2'd0) begin
                    errors++;
                    $display("FAIL rstmid_first got vld=%b idx=%0d exp vld=1 idx=0", grant_vld, grant_idx);
                end
            end
            tick();
        end
        checks++;
        if (beat_dat_q.size() < 2 || beat_dat_q[0] !== 8'h50 || beat_dat_q[1] !== 8'h60) begin
            errors++;
            $display("FAIL rstmid_log got n=%0d exp first beats 50 then 60", beat_dat_q.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0 && src_q[i].size() < 6)
                    src_q[i].push_back(8'($urandom_range(255)));
            m_ready = ($urandom_range(3) != 0);
            apply_src();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
        s_valid = '0;
        s_data  = '0;
        test_reset();
        test_single();
        test_saturated();
        test_stall();
        test_early_release();
        test_contention_idle();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream valid/ready byte channel (the slave-side input) among N_REQ upstream valid/ready masters. It holds a grant for a bounded burst of beats, then rotates fairly. It sits between the master instances and the single slave and owns all sequencing of the shared channel.

Parameters:
N_REQ, 4, number of requesting masters (2..16)
DW, 8, data width per requester, in bits
MAX_BURST, 4, maximum beats per grant before forced rotation (>=1)
IDW, $clog2(N_REQ), width of the grant index (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
s_valid  in  N_REQ  per-requester valid
s_ready  out  N_REQ  per-requester ready
s_data  in  N_REQ*DW  requester data; requester i occupies bits [i*DW +: DW]
m_valid  out  1  downstream valid
m_ready  in  1  downstream ready (slave not busy)
m_data  out  DW  downstream data
grant_vld  out  1  a grant is currently held
grant_idx  out  IDW  index of the granted requester (0 when grant_vld=0)

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- States: IDLE (no grant), GRANT (grant held).
- Reset (async, immediate): state=IDLE, grant_idx=0, grant_vld=0, rr_ptr=0, burst_cnt=0. m_valid=0 and s_ready=0 during and after reset until a grant is taken. Reset mid-burst abandons the burst. No beat completes in the reset cycle.
- Pick function: first i with s_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
- IDLE: if any s_valid is set, register grant_idx=pick and burst_cnt=0 at the edge, then enter GRANT. Latency is 1 cycle from s_valid rising to m_valid. m_valid=0 throughout IDLE.
- GRANT datapath (combinational from the grant register):
  - m_valid = s_valid[g], m_data = s_data[g].
  - s_ready[g] = m_ready; every other s_ready = 0.
  - No combinational path from m_ready to m_valid.
- Beat: m_valid & m_ready. Each beat increments burst_cnt.
- Release conditions in GRANT:
  - (a) a beat occurs while burst_cnt == MAX_BURST-1, or
  - (b) s_valid[g] == 0 (requester idle or done).
- On release:
  - rr_ptr = (g+1) mod N_REQ.
  - Re-arbitrate in the same edge using current s_valid, searching from the new rr_ptr.
  - If a pick exists: stay in GRANT with the new grant_idx and burst_cnt=0. Handover costs no bubble cycle.
  - If no pick exists: go to IDLE.
  - The previous owner stays eligible but has the lowest priority.
- Stall: m_ready=0 with s_valid[g]=1 holds the grant indefinitely. burst_cnt is frozen and data must remain stable (upstream rule).
- Simultaneous events: release (a) and a new request arriving on the same edge are resolved in one arbitration. A request that rises during GRANT waits its round-robin turn.
- Fairness: with all N_REQ requesters saturated, each gets exactly MAX_BURST beats in index order. Wait bound is (N_REQ-1)*MAX_BURST beats plus stalls.
- Wrap: rr_ptr and the search wrap at N_REQ-1 -> 0. burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
- N_REQ not a power of 2: indices >= N_REQ are never granted.

Decomposition:
- Shared package vr_pkg:
  - state enum {IDLE, GRANT}
  - default DW and N_REQ constants
  - rr_pick function (request vector, start pointer) -> {found, idx}
- One natural sub-module: rr_pick_comb, a combinational rotate/priority-encode/unrotate used by both IDLE and the release path. The state machine, counters and mux stay in the top.

Test Plan:
- Single requester: s_valid[1]=1, m_ready=1, data 0x10..0x17 -> m_valid rises 1 cycle later. grant_idx=1 with 4 beats (0x10..0x13), then re-grant to 1 with no bubble, then 0x14..0x17.
- All four saturated, m_ready=1 -> beat owners 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0 with no idle cycles between grants.
- Stall: grant to 2, m_ready=0 for 5 cycles mid-burst -> grant_idx stays 2, m_data stable, burst_cnt unchanged, and the burst completes after m_ready returns.
- Early release: requester 3 drops s_valid after 2 beats while requester 0 waits -> the next edge grants 0 with rr_ptr=0. Requester 3 got only 2 beats.
- Contention after idle: s_valid=4'b1010 rising together from IDLE with rr_ptr=2 -> grant 3 first, then 1.
- Reset mid-burst: assert rst during beat 2 of grant 1 -> m_valid=0, s_ready=0, grant_vld=0 immediately. After release, s_valid[0] is granted first (rr_ptr=0).
